// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one AES-128 core among
// N_REQ requesters, with a watchdog that aborts on a hung core.
module aes_core_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 64,
    localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [128*N_REQ-1:0] req_key,
    input  logic [128*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [127:0]         rsp_data,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [127:0]         core_key,
    output logic [127:0]         core_plaintext,
    input  logic [127:0]         core_ciphertext,
    input  logic                 core_ready,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] gid_q, gid_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  pt_q, pt_d;
    logic [127:0]  dat_q, dat_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [GW-1:0] win, idx;
    logic          found;
    logic          timeout;

    // First pending requester strictly after the last owner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GW'((int'(rr_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gid_d      = gid_q;
        key_d      = key_q;
        pt_d       = pt_q;
        dat_d      = dat_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst_n && core_ready && found) begin
                    req_ready[win] = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (win == GW'(i)) begin
                            key_d = req_key[128*i +: 128];
                            pt_d  = req_data[128*i +: 128];
                        end
                    end
                    gid_d   = win;
                    rr_d    = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                cnt_d = cnt_inc;
                if (timeout) begin
                    dat_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (!core_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (core_ready) begin
                    dat_d   = core_ciphertext;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout) begin
                    dat_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[gid_q] = 1'b1;
                if (rsp_ready[gid_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= GW'(N_REQ - 1);
            gid_q   <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign grant_id       = gid_q;
    assign core_key       = key_q;
    assign core_plaintext = pt_q;
    assign rsp_data       = dat_q;
    assign rsp_err        = err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: mock AES core, directed vector table and
// randomized traffic against a round-robin reference.
module tb_aes_core_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_ready;
    logic [128*N-1:0]   req_key, req_data;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready = '0;
    logic [127:0]       rsp_data;
    logic               rsp_err;
    logic               core_start;
    logic [127:0]       core_key, core_plaintext;
    logic [127:0]       core_ciphertext;
    logic               core_ready;
    logic               busy;
    logic [1:0]         grant_id;

    logic [127:0] keys [N];
    logic [127:0] datas[N];

    int total = 0;
    int bad   = 0;
    int starts = 0;

    for (genvar i = 0; i < N; i++) begin : g_pk
        assign req_key[128*i +: 128]  = keys[i];
        assign req_data[128*i +: 128] = datas[i];
    end

    aes_core_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_key(core_key),
        .core_plaintext(core_plaintext),
        .core_ciphertext(core_ciphertext),
        .core_ready(core_ready), .busy(busy), .grant_id(grant_id)
    );

    function automatic logic [127:0] mock(input logic [127:0] k,
                                          input logic [127:0] p);
        return k ^ {p[63:0], p[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    // Mock core: ready stays high cfg_hold cycles after start, then low
    // cfg_low cycles, then rises with the result. nodrop/norise hang it.
    int cfg_hold = 0, cfg_low = 3;
    bit cfg_nodrop = 0, cfg_norise = 0, kick = 0;
    int m_hold, m_low, m_cnt;
    bit m_nodrop, m_norise, m_act;
    logic [127:0] m_k, m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready      <= 1'b1;
            core_ciphertext <= '0;
            m_act           <= 1'b0;
            m_cnt           <= 0;
        end else if (kick) begin
            core_ready <= 1'b1;
            m_act      <= 1'b0;
        end else if (core_start) begin
            m_act    <= 1'b1;
            m_cnt    <= 0;
            m_k      <= core_key;
            m_p      <= core_plaintext;
            m_hold   <= cfg_hold;
            m_low    <= cfg_low;
            m_nodrop <= cfg_nodrop;
            m_norise <= cfg_norise;
        end else if (m_act) begin
            m_cnt <= m_cnt + 1;
            if (m_nodrop || m_cnt < m_hold) begin
                core_ready <= 1'b1;
            end else if (m_cnt < m_hold + m_low || m_norise) begin
                core_ready <= 1'b0;
            end else begin
                core_ready      <= 1'b1;
                core_ciphertext <= mock(m_k, m_p);
                m_act           <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (core_start === 1'b1) starts <= starts + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference arbiter: nearest pending requester after the last owner.
    function automatic int pick(input logic [N-1:0] vm, input int last);
        int best, bd, d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            d = (i - last - 1 + 2 * N) % N;
            if (vm[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    // One full transaction; called at a negedge, returns at the
    // negedge (+1) of the IDLE cycle following the response handshake.
    task automatic txn(input logic [N-1:0] vm, input logic [N-1:0] pend,
                       input int g, input bit keep, input int rdly,
                       input bit err, input int lat);
        int t, s0;
        logic [127:0] ed;
        logic [N-1:0] oh;
        oh    = '0;
        oh[g] = 1'b1;
        ed    = err ? 128'd0 : mock(keys[g], datas[g]);
        s0    = starts;
        req_valid = vm;
        #1;
        t = 0;
        while (req_ready === '0 && t < 300) begin
            @(negedge clk); #1; t++;
        end
        chk("grant", req_ready, oh);
        @(negedge clk);
        if (!keep) req_valid[g] = 1'b0;
        req_valid = req_valid | pend;
        if (rdly < 0) rsp_ready = '1;
        #1;
        chk("core_start", core_start, 1);
        chk("grant_id", grant_id, g);
        chk("core_key", core_key, keys[g]);
        chk("core_pt", core_plaintext, datas[g]);
        t = 0;
        while (rsp_valid === '0 && t < 300) begin
            @(negedge clk); #1; t++;
        end
        chk("latency", t, lat);
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, err);
        if (rdly >= 0) begin
            rsp_ready = ~oh;
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk); #1;
                chk("hold_valid", rsp_valid, oh);
                chk("hold_data", rsp_data, ed);
                chk("hold_quiet", {req_ready, core_start}, 0);
            end
            rsp_ready = oh;
        end
        @(negedge clk);
        rsp_ready = '0;
        #1;
        chk("rsp_done", {rsp_valid, busy}, 0);
        chk("one_start", starts - s0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] vm;
        int           g;
        int           rdly;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, rr_m;
        tbl[0]  = '{4'b1111, 0, 0};
        tbl[1]  = '{4'b1111, 1, 1};
        tbl[2]  = '{4'b1111, 2, -1};
        tbl[3]  = '{4'b1111, 3, 2};
        tbl[4]  = '{4'b1111, 0, 0};
        tbl[5]  = '{4'b1111, 1, 3};
        tbl[6]  = '{4'b1111, 2, 0};
        tbl[7]  = '{4'b1111, 3, -1};
        tbl[8]  = '{4'b1001, 0, 0};
        tbl[9]  = '{4'b1001, 3, 1};
        tbl[10] = '{4'b0110, 1, 0};
        tbl[11] = '{4'b0110, 2, 0};
        tbl[12] = '{4'b0001, 0, 2};
        tbl[13] = '{4'b1000, 3, 0};
        tbl[14] = '{4'b0101, 0, 0};
        for (int i = 0; i < N; i++) begin
            keys[i]  = '0;
            datas[i] = '0;
        end

        // Reset state, with requests already pending.
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", {req_ready, rsp_valid, busy, core_start, rsp_err, grant_id}, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_key", core_key ^ core_plaintext, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, 11-cycle core.
        keys[1]  = 128'h000102030405060708090a0b0c0d0e0f;
        datas[1] = 128'h00112233445566778899aabbccddeeff;
        cfg_hold = 0; cfg_low = 11;
        txn(4'b0010, '0, 1, 0, 0, 0, 14);

        // Stale ready for 2 cycles after start.
        keys[2] = 128'hfeedface; datas[2] = 128'hc0ffee;
        cfg_hold = 2; cfg_low = 5;
        txn(4'b0100, '0, 2, 0, 0, 0, 10);

        // Hung core: ready never drops.
        cfg_hold = 0; cfg_low = 1; cfg_nodrop = 1;
        txn(4'b0001, '0, 0, 0, 1, 1, TO + 1);

        // Hung core: ready never rises again.
        cfg_nodrop = 0; cfg_norise = 1;
        txn(4'b1000, '0, 3, 0, 0, 1, TO + 1);
        kick = 1;
        @(negedge clk);
        kick = 0;
        cfg_norise = 0; cfg_low = 4;
        keys[1] = 128'h1234; datas[1] = 128'h5678;
        txn(4'b0010, '0, 1, 0, 0, 0, 7);

        // Backpressure with requester 2 waiting, then back-to-back grant.
        keys[0] = 128'hab; keys[2] = 128'hcd;
        txn(4'b0001, 4'b0100, 0, 0, 5, 0, 7);
        chk("b2b_grant", req_ready, 4'b0100);
        txn(4'b0100, '0, 2, 0, 0, 0, 7);

        // Directed vector table from a fresh reset.
        do_reset();
        cfg_hold = 0; cfg_low = 2;
        for (int v = 0; v < 15; v++) begin
            for (int i = 0; i < N; i++) begin
                keys[i]  = {$urandom, $urandom, $urandom, $urandom};
                datas[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            txn(tbl[v].vm, '0, tbl[v].g, 1, tbl[v].rdly, 0, 5);
        end

        // Asynchronous reset during WAIT_DONE.
        req_valid = '0;
        cfg_low = 20;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        t = 0;
        while (req_ready === '0 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk("rst_txn_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1111;
        repeat (6) @(negedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {busy, rsp_valid, core_start, req_ready}, 0);
        chk("rst_gid", grant_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_low = 3;
        txn(4'b1111, '0, 0, 0, 0, 0, 6);

        // Randomized traffic against the reference arbiter.
        rr_m = 0;
        for (int it = 0; it < 150; it++) begin
            logic [N-1:0] vm;
            int g, rd;
            vm = N'($urandom_range(1, 2 ** N - 1));
            for (int i = 0; i < N; i++) begin
                keys[i]  = {$urandom, $urandom, $urandom, $urandom};
                datas[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            cfg_hold = $urandom_range(0, 2);
            cfg_low  = $urandom_range(1, 10);
            rd = int'($urandom_range(0, 4)) - 1;
            g  = pick(vm, rr_m);
            txn(vm, '0, g, 0, rd, 0, cfg_hold + cfg_low + 3);
            rr_m = g;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
